ptp_ts_queue: RTL and testbench
===============================

Name: ptp_ts_queue

Overview:
- Buffers per-frame PTP timestamps from the timestamp-extract stage, which emits one timestamp per frame and has no backpressure.
- Tags each timestamp with a running frame sequence number and presents it on a ready/valid stream for software or a descriptor engine.
- Sits directly downstream of timestamp extraction on the MAC TX/RX timestamp path.
- Absorbs consumer stalls and counts timestamps lost to overflow.

Parameters:
- TS_WIDTH, 96: timestamp width in bits.
- TAG_WIDTH, 16: sequence tag width in bits.
- DEPTH, 16: storage entries, including the output register. Must be a power of two, ≥2.
- CNT_WIDTH, 16: width of the drop counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_axis_ts  input  TS_WIDTH  timestamp from extract stage
- s_axis_ts_valid  input  1  single-cycle strobe, one per frame, no ready
- m_axis_ts  output  TS_WIDTH  queued timestamp
- m_axis_ts_tag  output  TAG_WIDTH  sequence tag of the queued timestamp
- m_axis_ts_valid  output  1  output entry valid
- m_axis_ts_ready  input  1  consumer accept
- status_level  output  $clog2(DEPTH)+1  entries held, including the output register
- status_drop_count  output  CNT_WIDTH  saturating count of dropped timestamps
- status_overflow  output  1  one-cycle pulse on each drop

Behaviour:
- Reset (rst_n low, asynchronous):
  - Clears pointers, level, tag counter, drop counter and the output register.
  - m_axis_ts_valid=0, m_axis_ts=0, m_axis_ts_tag=0, status_level=0, status_drop_count=0, status_overflow=0.
  - Deassertion is used synchronously; no input is accepted in the first cycle rst_n is high.
  - Reset mid-operation discards all entries and the tag restarts at 0.
- Tag counter:
  - Increments by 1, modulo 2^TAG_WIDTH, on every cycle s_axis_ts_valid=1, whether the entry is stored or dropped.
  - The stored tag is the pre-increment value. Dropped timestamps therefore appear as tag gaps downstream.
- Storage:
  - Circular RAM of DEPTH-1 entries plus one output register.
  - First-word-fall-through: an input into an empty queue at cycle N gives m_axis_ts_valid=1 at cycle N+1, so latency is 1 cycle.
  - Outputs are always registered. m_axis_ts and m_axis_ts_tag hold stable while valid && !ready.
- Handshake:
  - Transfer occurs when m_axis_ts_valid && m_axis_ts_ready.
  - The next entry, if any, is loaded in the same edge, allowing one pop per cycle.
  - m_axis_ts_valid never depends combinationally on m_axis_ts_ready.
- Full condition: status_level==DEPTH.
  - Push while full with no pop in the same cycle is dropped:
    - status_overflow pulses for 1 cycle.
    - status_drop_count increments, saturating at all-ones.
  - Push while full with a pop in the same cycle is accepted; level stays DEPTH.
- Simultaneous push and pop when not full: level unchanged, order preserved.
- Empty queue with ready high: m_axis_ts_valid stays 0 and ready is ignored.
- Pointers wrap modulo DEPTH-1 RAM entries. The level arithmetic is exact with no aliasing at full.
- The drop counter clears only on reset.

Optional Feature:
- Macro PTP_TS_QUEUE_DROP_OLDEST_EN.
- Defined: a push while full with no pop evicts the oldest entry (the output register is advanced) and stores the new timestamp.
  - status_overflow pulses and status_drop_count increments.
  - Level stays DEPTH.
  - m_axis_ts_valid stays 1, but the presented entry changes. This change is permitted only in this mode.
- Not defined: newest-dropped behaviour as specified above.

Test Plan:
- Single strobe ts=0x1234 into empty queue, ready=1 -> m_axis_ts_valid=1 one cycle later with ts=0x1234, tag=0. Next cycle valid=0 and level=0.
- 16 strobes (ts=1..16) with ready=0, then a 17th (ts=17) -> level=16, overflow pulse, drop_count=1. Then ready=1 drains ts 1..16 with tags 0..15 on consecutive cycles, and the next push gets tag 17.
- Full queue, strobe coincident with a ready handshake -> no drop, level stays 16, and the last drained entry is the new ts with the correct tag.
- Ready toggled 1/0 each cycle while strobing every cycle -> outputs stable during stalls, no loss or reorder until full, tags contiguous.
- rst_n asserted mid-drain with 5 entries held -> immediately valid=0, level=0, drop_count=0. First post-reset push gets tag 0.
- With PTP_TS_QUEUE_DROP_OLDEST_EN, a full queue plus strobe ts=99 -> head advances from ts=1 to ts=2, and the tail is ts=99.

Source files
------------

// File: rtl/ptp_ts_queue.sv
// Per-frame PTP timestamp queue: tags each strobe with a running sequence number and
// presents it FWFT on ready/valid. Optional macro PTP_TS_QUEUE_DROP_OLDEST_EN evicts the head on overflow.
module ptp_ts_queue #(
    parameter int TS_WIDTH  = 96,
    parameter int TAG_WIDTH = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [TS_WIDTH-1:0]        s_axis_ts,
    input  logic                       s_axis_ts_valid,
    output logic [TS_WIDTH-1:0]        m_axis_ts,
    output logic [TAG_WIDTH-1:0]       m_axis_ts_tag,
    output logic                       m_axis_ts_valid,
    input  logic                       m_axis_ts_ready,
    output logic [$clog2(DEPTH):0]     status_level,
    output logic [CNT_WIDTH-1:0]       status_drop_count,
    output logic                       status_overflow
);
    localparam int LW        = $clog2(DEPTH) + 1;
    localparam int RAM_DEPTH = DEPTH - 1;
    localparam int PW        = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int EW        = TAG_WIDTH + TS_WIDTH;

    logic [EW-1:0]        mem [RAM_DEPTH];
    logic [PW-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [LW-1:0]        ram_count_reg, ram_count_next;
    logic                 out_valid_reg, out_valid_next;
    logic [EW-1:0]        out_data_reg, out_data_next;
    logic [TAG_WIDTH-1:0] tag_reg, tag_next;
    logic [CNT_WIDTH-1:0] drop_count_reg, drop_count_next;
    logic                 overflow_reg, overflow_next;
    logic                 run_reg;
    logic                 mem_we;
    logic                 push, pop, full;
    logic [EW-1:0]        in_entry, ram_head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Inputs are ignored for the first cycle after reset release.
    assign push     = s_axis_ts_valid && run_reg;
    assign pop      = out_valid_reg && m_axis_ts_ready;
    assign full     = out_valid_reg && (ram_count_reg == LW'(RAM_DEPTH));
    assign in_entry = {tag_reg, s_axis_ts};
    assign ram_head = mem[rd_ptr_reg];

    always_comb begin
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;
        ram_count_next  = ram_count_reg;
        out_valid_next  = out_valid_reg;
        out_data_next   = out_data_reg;
        drop_count_next = drop_count_reg;
        overflow_next   = 1'b0;
        mem_we          = 1'b0;
        tag_next        = tag_reg + TAG_WIDTH'(push);

        if (!out_valid_reg) begin
            if (push) begin
                out_valid_next = 1'b1;
                out_data_next  = in_entry;
            end
        end else if (pop) begin
            if (ram_count_reg != '0) begin
                out_data_next = ram_head;
                rd_ptr_next   = ptr_inc(rd_ptr_reg);
                if (push) begin
                    // Write and read may hit the same slot when full; the read sees the old entry.
                    mem_we      = 1'b1;
                    wr_ptr_next = ptr_inc(wr_ptr_reg);
                end else begin
                    ram_count_next = ram_count_reg - 1'b1;
                end
            end else if (push) begin
                out_data_next = in_entry;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (push) begin
            if (!full) begin
                mem_we         = 1'b1;
                wr_ptr_next    = ptr_inc(wr_ptr_reg);
                ram_count_next = ram_count_reg + 1'b1;
            end else begin
                overflow_next = 1'b1;
                if (drop_count_reg != '1) begin
                    drop_count_next = drop_count_reg + 1'b1;
                end
`ifdef PTP_TS_QUEUE_DROP_OLDEST_EN
                out_data_next = ram_head;
                rd_ptr_next   = ptr_inc(rd_ptr_reg);
                mem_we        = 1'b1;
                wr_ptr_next   = ptr_inc(wr_ptr_reg);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg        <= 1'b0;
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            ram_count_reg  <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            tag_reg        <= '0;
            drop_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            run_reg        <= 1'b1;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
            ram_count_reg  <= ram_count_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            tag_reg        <= tag_next;
            drop_count_reg <= drop_count_next;
            overflow_reg   <= overflow_next;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    assign m_axis_ts         = out_data_reg[TS_WIDTH-1:0];
    assign m_axis_ts_tag     = out_data_reg[EW-1:TS_WIDTH];
    assign m_axis_ts_valid   = out_valid_reg;
    assign status_level      = ram_count_reg + LW'(out_valid_reg);
    assign status_drop_count = drop_count_reg;
    assign status_overflow   = overflow_reg;
endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed self-checking bench for ptp_ts_queue; the drop-oldest scenario runs when
// PTP_TS_QUEUE_DROP_OLDEST_EN is defined.
module tb_ptp_ts_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [95:0] s_axis_ts = '0;
    logic        s_axis_ts_valid = 1'b0;
    logic [95:0] m_axis_ts;
    logic [15:0] m_axis_ts_tag;
    logic        m_axis_ts_valid;
    logic        m_axis_ts_ready = 1'b0;
    logic [4:0]  status_level;
    logic [15:0] status_drop_count;
    logic        status_overflow;

    int checks = 0;
    int failures = 0;

    ptp_ts_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_axis_ts         (s_axis_ts),
        .s_axis_ts_valid   (s_axis_ts_valid),
        .m_axis_ts         (m_axis_ts),
        .m_axis_ts_tag     (m_axis_ts_tag),
        .m_axis_ts_valid   (m_axis_ts_valid),
        .m_axis_ts_ready   (m_axis_ts_ready),
        .status_level      (status_level),
        .status_drop_count (status_drop_count),
        .status_overflow   (status_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_axis_ts_valid = 1'b0;
        m_axis_ts_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [95:0] ts);
        s_axis_ts = ts;
        s_axis_ts_valid = 1'b1;
        tick();
        s_axis_ts_valid = 1'b0;
    endtask

    initial begin
        int exp_idx;
        bit held;
        logic [95:0] held_ts;

        #2;
        chk("rst_valid", m_axis_ts_valid, 0);
        chk("rst_ts", m_axis_ts, 0);
        chk("rst_tag", m_axis_ts_tag, 0);
        chk("rst_level", status_level, 0);
        chk("rst_drop", status_drop_count, 0);
        chk("rst_ovf", status_overflow, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Single strobe, FWFT latency of one cycle
        m_axis_ts_ready = 1'b1;
        push(96'h1234);
        chk("single_valid", m_axis_ts_valid, 1);
        chk("single_ts", m_axis_ts, 96'h1234);
        chk("single_tag", m_axis_ts_tag, 0);
        chk("single_level", status_level, 1);
        tick();
        chk("single_valid_after", m_axis_ts_valid, 0);
        chk("single_level_after", status_level, 0);
        $display("txn single: ts=1234 tag=0");

        // Fill to full, then overflow
        do_reset();
        for (int i = 1; i <= 16; i++) push(96'(i));
        chk("full_level", status_level, 16);
        chk("full_ovf_before", status_overflow, 0);
        push(96'd17);
        chk("ovf_pulse", status_overflow, 1);
        chk("ovf_drop", status_drop_count, 1);
        chk("ovf_level", status_level, 16);
        chk("ovf_head_ts", m_axis_ts, 1);
        tick();
        chk("ovf_pulse_end", status_overflow, 0);
        m_axis_ts_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", m_axis_ts_valid, 1);
            chk("drain_ts", m_axis_ts, 96'(i + 1));
            chk("drain_tag", m_axis_ts_tag, 128'(i));
            $display("txn drain: ts=%0d tag=%0d", m_axis_ts, m_axis_ts_tag);
            tick();
        end
        chk("drained_valid", m_axis_ts_valid, 0);
        chk("drained_level", status_level, 0);
        m_axis_ts_ready = 1'b0;
        push(96'h55);
        chk("post_drop_tag", m_axis_ts_tag, 17);

        // Full queue with a push coincident with a pop
        do_reset();
        for (int i = 0; i < 16; i++) push(96'(100 + i));
        m_axis_ts_ready = 1'b1;
        push(96'd200);
        chk("pp_level", status_level, 16);
        chk("pp_ovf", status_overflow, 0);
        chk("pp_drop", status_drop_count, 0);
        chk("pp_head", m_axis_ts, 101);
        for (int i = 1; i < 16; i++) begin
            chk("pp_drain_ts", m_axis_ts, 96'(100 + i));
            chk("pp_drain_tag", m_axis_ts_tag, 128'(i));
            tick();
        end
        chk("pp_last_ts", m_axis_ts, 200);
        chk("pp_last_tag", m_axis_ts_tag, 16);
        $display("txn pushpop_full: last ts=%0d tag=%0d", m_axis_ts, m_axis_ts_tag);
        tick();
        chk("pp_empty", m_axis_ts_valid, 0);

        // Ready toggling while strobing every cycle
        do_reset();
        exp_idx = 0;
        held = 1'b0;
        held_ts = '0;
        for (int k = 0; k < 20; k++) begin
            s_axis_ts = 96'(300 + k);
            s_axis_ts_valid = 1'b1;
            m_axis_ts_ready = k[0];
            if (held) chk("tog_stable", m_axis_ts, held_ts);
            held = 1'b0;
            if (m_axis_ts_valid) begin
                if (m_axis_ts_ready) begin
                    chk("tog_ts", m_axis_ts, 96'(300 + exp_idx));
                    chk("tog_tag", m_axis_ts_tag, 128'(exp_idx));
                    $display("txn toggle: ts=%0d tag=%0d", m_axis_ts, m_axis_ts_tag);
                    exp_idx++;
                end else begin
                    held = 1'b1;
                    held_ts = m_axis_ts;
                end
            end
            tick();
        end
        s_axis_ts_valid = 1'b0;
        m_axis_ts_ready = 1'b1;
        for (int n = 0; n < 40 && exp_idx < 20; n++) begin
            if (m_axis_ts_valid) begin
                chk("tog_drain_ts", m_axis_ts, 96'(300 + exp_idx));
                chk("tog_drain_tag", m_axis_ts_tag, 128'(exp_idx));
                exp_idx++;
            end
            tick();
        end
        chk("tog_total", 128'(exp_idx), 20);
        chk("tog_drop", status_drop_count, 0);

        // Reset asserted mid-drain with 5 entries held
        do_reset();
        for (int i = 0; i < 17; i++) push(96'(500 + i));
        chk("mid_drop_before", status_drop_count, 1);
        m_axis_ts_ready = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("mid_level", status_level, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_axis_ts_valid, 0);
        chk("mid_rst_level", status_level, 0);
        chk("mid_rst_drop", status_drop_count, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_axis_ts_ready = 1'b0;
        push(96'h777);
        chk("first_cycle_ignored", status_level, 0);
        push(96'h888);
        chk("post_rst_valid", m_axis_ts_valid, 1);
        chk("post_rst_ts", m_axis_ts, 96'h888);
        chk("post_rst_tag", m_axis_ts_tag, 0);
        $display("txn post_reset: ts=%0h tag=%0d", m_axis_ts, m_axis_ts_tag);

`ifdef PTP_TS_QUEUE_DROP_OLDEST_EN
        do_reset();
        for (int i = 1; i <= 16; i++) push(96'(i));
        push(96'd99);
        chk("do_head_ts", m_axis_ts, 2);
        chk("do_head_tag", m_axis_ts_tag, 1);
        chk("do_valid", m_axis_ts_valid, 1);
        chk("do_level", status_level, 16);
        chk("do_ovf", status_overflow, 1);
        chk("do_drop", status_drop_count, 1);
        m_axis_ts_ready = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            chk("do_drain_ts", m_axis_ts, 96'(i));
            tick();
        end
        chk("do_tail_ts", m_axis_ts, 99);
        chk("do_tail_tag", m_axis_ts_tag, 16);
        $display("txn drop_oldest: tail ts=%0d tag=%0d", m_axis_ts, m_axis_ts_tag);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
